// File: rtl/panda_lsu_ctrl.sv
// rtl/panda_lsu_ctrl.sv - multi-cycle load/store unit with req/gnt/rvalid memory port
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   req_i, load_store_i,           core request (sampled only while idle), store select,
//   load_unsigned_i, width_i,      zero-extend select, access width (byte/half/word),
//   addr_i, store_data_i           byte address and register store data
//   busy_o, valid_o, err_o,        in-progress flag, completion pulse, error qualifier,
//   load_data_o                    extended load result (held until next completion)
//   data_req_o, data_gnt_i,        memory request/grant,
//   data_rvalid_i, data_rdata_i,   memory response,
//   data_addr_o, data_we_o,        word-aligned address, write enable,
//   data_be_o, data_wdata_o        byte enables, lane-rotated store data
module panda_lsu_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  load_store_i,
  input  logic                  load_unsigned_i,
  input  logic [1:0]            width_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [31:0]           load_data_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ1,
    S_WAIT1,
    S_REQ2,
    S_WAIT2,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            width_q;
  logic                  store_q;
  logic                  unsigned_q;
  logic [31:0]           sdata_q;
  logic [31:0]           rdata1_q;

  // An access crosses into the next word when offset + size exceeds 4 bytes.
  function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] w);
    logic [2:0] size;
    case (w)
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    return ({1'b0, off} + size) > 3'd4;
  endfunction

  logic [1:0]  off;
  logic        mis_q;
  logic [3:0]  size_mask;
  logic [7:0]  be_wide;
  logic [5:0]  shamt;
  logic [31:0] wdata_rep;
  logic [31:0] wdata_rot;
  logic [31:0] lo_word;
  logic [31:0] hi_word;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        finish;
  logic        in_req1;
  logic        in_req2;

  assign off     = addr_q[1:0];
  assign mis_q   = crosses_word(off, width_q);
  assign shamt   = {1'b0, off, 3'b000};
  assign be_wide = {4'b0000, size_mask} << off;
  assign in_req1 = (state_q == S_REQ1);
  assign in_req2 = (state_q == S_REQ2);

  always_comb begin
    size_mask = 4'b1111;
    wdata_rep = sdata_q;
    case (width_q)
      2'b00: begin
        size_mask = 4'b0001;
        wdata_rep = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        size_mask = 4'b0011;
        wdata_rep = {2{sdata_q[15:0]}};
      end
      default: begin
        size_mask = 4'b1111;
        wdata_rep = sdata_q;
      end
    endcase
  end

  // Rotate left by 8*off: the low half of {x,x} >> (32 - 8*off).
  assign wdata_rot = 32'({wdata_rep, wdata_rep} >> (6'd32 - shamt));

  // The first beat's data is live on the bus in WAIT1 and registered afterwards;
  // the upper word only exists for a split access.
  assign lo_word = (state_q == S_WAIT1) ? data_rdata_i : rdata1_q;
  assign hi_word = (state_q == S_WAIT2) ? data_rdata_i : 32'h0;
  assign shifted = 32'({hi_word, lo_word} >> shamt);

  always_comb begin
    load_ext = shifted;
    case (width_q)
      2'b00:   load_ext = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign finish = data_rvalid_i &
                  (((state_q == S_WAIT1) & ~mis_q) | (state_q == S_WAIT2));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (width_i == 2'b11 || (!MISALIGNED_EN && crosses_word(addr_i[1:0], width_i)))
            state_d = S_ERR;
          else
            state_d = S_REQ1;
        end
      end
      S_REQ1:  if (data_gnt_i) state_d = S_WAIT1;
      S_WAIT1: if (data_rvalid_i) state_d = mis_q ? S_REQ2 : S_IDLE;
      S_REQ2:  if (data_gnt_i) state_d = S_WAIT2;
      S_WAIT2: if (data_rvalid_i) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign data_req_o   = in_req1 | in_req2;
  assign data_we_o    = data_req_o & store_q;
  assign data_be_o    = in_req1 ? be_wide[3:0] : (in_req2 ? be_wide[7:4] : 4'b0000);
  assign data_wdata_o = data_req_o ? wdata_rot : 32'h0;
  assign data_addr_o  = data_req_o ?
                        ({addr_q[ADDR_WIDTH-1:2], 2'b00} + (in_req2 ? ADDR_WIDTH'(4) : '0)) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      width_q     <= 2'b00;
      store_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      sdata_q     <= 32'h0;
      rdata1_q    <= 32'h0;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      load_data_o <= 32'h0;
    end else begin
      state_q <= state_d;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (state_q == S_IDLE && req_i) begin
        addr_q     <= addr_i;
        width_q    <= width_i;
        store_q    <= load_store_i;
        unsigned_q <= load_unsigned_i;
        sdata_q    <= store_data_i;
      end
      if (state_q == S_WAIT1 && data_rvalid_i)
        rdata1_q <= data_rdata_i;
      if (finish) begin
        valid_o <= 1'b1;
        if (!store_q)
          load_data_o <= load_ext;
      end
      if (state_q == S_ERR) begin
        valid_o     <= 1'b1;
        err_o       <= 1'b1;
        load_data_o <= 32'h0;
      end
    end
  end

endmodule
